// File: rtl/transform_conv_to_mat.sv
// transform_conv_to_mat: buffers feature-map rows in a 4-slot ring and turns
// every 3-row window into three operand beats, one per kernel column, with
// each row shifted by -1/0/+1 lane and zero padding at the row edges.
module transform_conv_to_mat #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] in_row,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0] out_top,
    output logic [LANES-1:0][DATA_WIDTH-1:0] out_mid,
    output logic [LANES-1:0][DATA_WIDTH-1:0] out_bot,
    output logic [1:0]                       out_kcol,
    output logic                             out_frame_end,
    output logic                             out_valid,
    input  logic                             out_ready
);

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] row_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_EMIT,
        ST_RETIRE,
        ST_FLUSH
    } state_t;

    state_t     state;
    state_t     state_next;

    row_t       slots [4];
    logic [3:0] slot_last;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       flush_pending;

    logic [1:0] rd_p1;
    logic [1:0] rd_p2;
    logic [1:0] rd_p3;

    logic       push;
    logic       pop;
    logic       flush;
    logic       beat_load;
    logic       beat_clear;
    logic       beat_end;
    logic [1:0] beat_kcol;
    row_t       beat_top;
    row_t       beat_mid;
    row_t       beat_bot;

    // kcol 0 looks one lane to the left (lane j takes lane j-1), kcol 2 one
    // lane to the right; the lane shifted in from outside the row is zero.
    function automatic row_t shift_row(input row_t r, input logic [1:0] kcol);
        row_t s;
        case (kcol)
            2'd0:    s = r << DATA_WIDTH;
            2'd2:    s = r >> DATA_WIDTH;
            default: s = r;
        endcase
        return s;
    endfunction

    assign rd_p1 = rd_ptr + 2'd1;
    assign rd_p2 = rd_ptr + 2'd2;
    assign rd_p3 = rd_ptr + 2'd3;

    // A last row closes the input until the frame has been flushed.
    assign in_ready = enable & ~rst & (count < 3'd4) & ~flush_pending;
    assign push     = in_valid & in_ready;

    // Next-state and beat selection; RETIRE hands over straight to the next
    // window when it is already buffered, so windows are one idle cycle apart.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        flush      = 1'b0;
        beat_load  = 1'b0;
        beat_clear = 1'b0;
        beat_end   = 1'b0;
        beat_kcol  = 2'd0;
        beat_top   = slots[rd_ptr];
        beat_mid   = slots[rd_p1];
        beat_bot   = slots[rd_p2];
        case (state)
            ST_FILL: begin
                if (count >= 3'd3) begin
                    beat_load  = 1'b1;
                    state_next = ST_EMIT;
                end else if (flush_pending) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (out_kcol == 2'd2) begin
                        beat_clear = 1'b1;
                        state_next = ST_RETIRE;
                    end else begin
                        beat_load = 1'b1;
                        beat_kcol = out_kcol + 2'd1;
                        beat_end  = (out_kcol == 2'd1) & slot_last[rd_p2];
                    end
                end
            end
            ST_RETIRE: begin
                if (slot_last[rd_p2]) begin
                    state_next = ST_FLUSH;
                end else begin
                    pop      = 1'b1;
                    beat_top = slots[rd_p1];
                    beat_mid = slots[rd_p2];
                    beat_bot = push ? in_row : slots[rd_p3];
                    if ((count == 3'd4) || ((count == 3'd3) && push)) begin
                        beat_load  = 1'b1;
                        state_next = ST_EMIT;
                    end else begin
                        state_next = ST_FILL;
                    end
                end
            end
            ST_FLUSH: begin
                flush      = 1'b1;
                state_next = ST_FILL;
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // State register; a low enable freezes the sequence in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Row ring: slot storage, pointers, occupancy and the frame-closed flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slots[i] <= '0;
            end
            slot_last     <= '0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            count         <= 3'd0;
            flush_pending <= 1'b0;
        end else if (enable) begin
            if (push) begin
                slots[wr_ptr]     <= in_row;
                slot_last[wr_ptr] <= in_last;
            end
            if (flush) begin
                wr_ptr        <= 2'd0;
                rd_ptr        <= 2'd0;
                count         <= 3'd0;
                flush_pending <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end
                count <= count + {2'b00, push} - {2'b00, pop};
                if (push && in_last) begin
                    flush_pending <= 1'b1;
                end
            end
        end
    end

    // Output beat registers; they only change on a load or once the final
    // kernel column has been taken, so a stalled beat stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_top       <= '0;
            out_mid       <= '0;
            out_bot       <= '0;
            out_kcol      <= 2'd0;
            out_frame_end <= 1'b0;
            out_valid     <= 1'b0;
        end else if (enable) begin
            if (beat_load) begin
                out_top       <= shift_row(beat_top, beat_kcol);
                out_mid       <= shift_row(beat_mid, beat_kcol);
                out_bot       <= shift_row(beat_bot, beat_kcol);
                out_kcol      <= beat_kcol;
                out_frame_end <= beat_end;
                out_valid     <= 1'b1;
            end else if (beat_clear) begin
                out_frame_end <= 1'b0;
                out_valid     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transform_conv_to_mat.sv
// Testbench for transform_conv_to_mat: frames of rows go in, every accepted
// beat is recorded and compared against a window model built from the rows.
module tb_transform_conv_to_mat;

    localparam int DW    = 16;
    localparam int LANES = 8;

    typedef logic [LANES-1:0][DW-1:0] row_t;

    typedef struct packed {
        row_t       top;
        row_t       mid;
        row_t       bot;
        logic [1:0] kcol;
        logic       fe;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    row_t       in_row;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    row_t       out_top;
    row_t       out_mid;
    row_t       out_bot;
    logic [1:0] out_kcol;
    logic       out_frame_end;
    logic       out_valid;
    logic       out_ready;

    int    checks = 0;
    int    errors = 0;
    row_t  cur_rows[$];
    beat_t got_q[$];
    beat_t exp_q[$];

    int    acc_rows;
    int    done_wins;
    bit    saw_full;
    logic  vq[$];

    transform_conv_to_mat #(.DATA_WIDTH(DW), .LANES(LANES)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .in_row        (in_row),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_top       (out_top),
        .out_mid       (out_mid),
        .out_bot       (out_bot),
        .out_kcol      (out_kcol),
        .out_frame_end (out_frame_end),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    // Record every beat that will be handed over at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && enable && out_valid && out_ready)
            got_q.push_back(beat_t'({out_top, out_mid, out_bot, out_kcol, out_frame_end}));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input int n, input bit counting);
        row_t r;
        cur_rows.delete();
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < LANES; j++)
                r[j[2:0]] = counting ? 16'(16 * k + j) : 16'($urandom());
            cur_rows.push_back(r);
        end
    endtask

    // Lane j of kernel column k is lane j+k-1 of the source row, 0 outside.
    function automatic row_t window_col(input int r, input int k);
        row_t s;
        int   idx;
        for (int j = 0; j < LANES; j++) begin
            idx = j + k - 1;
            if (idx < 0 || idx >= LANES) s[j[2:0]] = '0;
            else                         s[j[2:0]] = cur_rows[r][idx[2:0]];
        end
        return s;
    endfunction

    function automatic void build_expected();
        beat_t b;
        int    n;
        n = cur_rows.size();
        exp_q.delete();
        for (int w = 0; w + 2 < n; w++) begin
            for (int k = 0; k < 3; k++) begin
                b.top  = window_col(w, k);
                b.mid  = window_col(w + 1, k);
                b.bot  = window_col(w + 2, k);
                b.kcol = k[1:0];
                b.fe   = (w + 3 == n) && (k == 2);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic send_rows(input int first, input int stop);
        int   wc;
        logic acc;
        for (int i = first; i < stop; i++) begin
            in_row   = cur_rows[i];
            in_valid = 1'b1;
            in_last  = (i == cur_rows.size() - 1);
            wc  = 0;
            acc = 1'b0;
            while (!acc && wc < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                wc++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("[TB] FAIL send_row %0d: in_ready stayed 0, required 1 within 200 cycles", i);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b required 0", out_valid); end
        checks++;
        if (out_kcol !== 2'd0) begin errors++; $display("[TB] FAIL reset out_kcol: got %0d required 0", out_kcol); end
        checks++;
        if (out_frame_end !== 1'b0) begin errors++; $display("[TB] FAIL reset out_frame_end: got %b required 0", out_frame_end); end
        checks++;
        if ({out_top, out_mid, out_bot} !== '0) begin errors++; $display("[TB] FAIL reset out data: got %h required 0", {out_top, out_mid, out_bot}); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset in_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_three_row();
        make_frame(3, 1'b1);
        build_expected();
        got_q.delete();
        out_ready = 1'b1;
        send_rows(0, 3);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency at T: out_valid=%b required 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_kcol !== 2'd0) begin
            errors++; $display("[TB] FAIL latency at T+1: out_valid=%b kcol=%0d required 1/0", out_valid, out_kcol);
        end
        repeat (10) step();
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL three_row beat count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL three_row beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 3) begin
            checks++;
            if (got_q[0].top[1] !== 16'd0 || got_q[0].top[0] !== 16'd0 || got_q[0].top[7] !== 16'd6) begin
                errors++; $display("[TB] FAIL kcol0 top lanes: got %h required lanes {0,0..6}", got_q[0].top);
            end
            checks++;
            if (got_q[1].mid[0] !== 16'd16 || got_q[1].mid[7] !== 16'd23) begin
                errors++; $display("[TB] FAIL kcol1 mid lanes: got %h required 16..23", got_q[1].mid);
            end
            checks++;
            if (got_q[2].bot[0] !== 16'd33 || got_q[2].bot[6] !== 16'd39 || got_q[2].bot[7] !== 16'd0) begin
                errors++; $display("[TB] FAIL kcol2 bot lanes: got %h required {33..39,0}", got_q[2].bot);
            end
            checks++;
            if ({got_q[0].fe, got_q[1].fe, got_q[2].fe} !== 3'b001) begin
                errors++; $display("[TB] FAIL frame_end flags: got %b required 001", {got_q[0].fe, got_q[1].fe, got_q[2].fe});
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx[$];
        int occ;
        make_frame(5, 1'b0);
        build_expected();
        got_q.delete();
        vq.delete();
        acc_rows  = 0;
        done_wins = 0;
        saw_full  = 1'b0;
        out_ready = 1'b1;
        fork
            send_rows(0, 5);
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    vq.push_back(out_valid);
                    occ = acc_rows - done_wins;
                    if (occ == 4) begin
                        saw_full = 1'b1;
                        checks++;
                        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL in_ready at four rows: got %b required 0", in_ready); end
                    end
                    if (in_valid && in_ready) acc_rows++;
                    if (out_valid && out_ready && out_kcol == 2'd2) done_wins++;
                end
            end
        join
        repeat (4) step();
        checks++;
        if (!saw_full) begin errors++; $display("[TB] FAIL ring_full reached: got 0 required 1"); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL b2b beat count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < vq.size(); i++)
            if (vq[i] === 1'b1) idx.push_back(i);
        for (int b = 1; b < idx.size() && b < 9; b++) begin
            checks++;
            if (idx[b] - idx[b - 1] !== ((b % 3 == 0) ? 2 : 1)) begin
                errors++; $display("[TB] FAIL b2b spacing before beat %0d: got %0d cycles required %0d", b, idx[b] - idx[b - 1], (b % 3 == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_stall();
        int wc;
        make_frame(3, 1'b0);
        build_expected();
        got_q.delete();
        out_ready = 1'b0;
        send_rows(0, 3);
        wc = 0;
        while (!out_valid && wc < 20) begin step(); wc++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall first beat: out_valid=%b required 1 within 20 cycles", out_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_kcol !== 2'd1 || {out_top, out_mid, out_bot} !== {exp_q[1].top, exp_q[1].mid, exp_q[1].bot}) begin
                errors++; $display("[TB] FAIL stall hold cycle %0d: valid=%b kcol=%0d mid=%h required 1/1/%h", c, out_valid, out_kcol, out_mid, exp_q[1].mid);
            end
            if (c < 2) step();
        end
        out_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL stall beat count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_short_frame();
        make_frame(2, 1'b0);
        got_q.delete();
        out_ready = 1'b1;
        send_rows(0, 2);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL short in_ready after last: got %b required 0", in_ready); end
        repeat (10) step();
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL short frame beats: got %0d required 0", got_q.size()); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL short in_ready after flush: got %b required 1", in_ready); end
        make_frame(3, 1'b0);
        build_expected();
        got_q.delete();
        send_rows(0, 3);
        repeat (10) step();
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL short_next beat count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL short_next beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_enable();
        beat_t snap;
        make_frame(5, 1'b0);
        build_expected();
        got_q.delete();
        out_ready = 1'b1;
        send_rows(0, 3);
        repeat (2) step();
        enable = 1'b0;
        snap = beat_t'({out_top, out_mid, out_bot, out_kcol, out_frame_end});
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (beat_t'({out_top, out_mid, out_bot, out_kcol, out_frame_end}) !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL freeze cycle %0d: valid=%b in_ready=%b kcol=%0d required 1/0/%0d, data stable", c, out_valid, in_ready, out_kcol, snap.kcol);
            end
        end
        enable = 1'b1;
        send_rows(3, 5);
        repeat (20) step();
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL enable beat count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL enable beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        make_frame(3, 1'b0);
        got_q.delete();
        out_ready = 1'b1;
        send_rows(0, 3);
        repeat (2) step();
        checks++;
        if (out_valid !== 1'b1 || out_kcol !== 2'd1) begin errors++; $display("[TB] FAIL pre-reset beat: valid=%b kcol=%0d required 1/1", out_valid, out_kcol); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_kcol !== 2'd0 || {out_top, out_mid, out_bot} !== '0 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL async reset: valid=%b kcol=%0d in_ready=%b required all zero", out_valid, out_kcol, in_ready);
        end
        repeat (2) step();
        rst = 1'b0;
        make_frame(3, 1'b0);
        build_expected();
        got_q.delete();
        send_rows(0, 3);
        repeat (10) step();
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL after_reset beat count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL after_reset beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        in_row    = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_three_row();
        test_back_to_back();
        test_stall();
        test_short_frame();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
